dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data-cache controller sitting between the CPU load/store port and the main data memory. It initiates all main-memory traffic: 4-word line fills on read misses (EnMain_Rd) and single-word write-throughs (Mem_Wr). Completion of each memory transaction is signalled by the memory's one-cycle Ready pulse.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_line_store.sv | 52 +++++
 rtl/dcache_ctrl.sv | 150 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int OFFSET_W = 2;
  localparam int WORDS    = 4;
  localparam int CNT_W    = 16;

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - OFFSET_W - $clog2(lines);
  endfunction

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: one whole-line fill port, one single-word write port,
// and a combinational lookup returning the indexed line and its hit flag.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 32,
  parameter int IW         = index_w(LINES),
  parameter int TW         = 3
) (
  input  logic                              CLK,
  input  logic                              rst_n,
  input  logic                              i_fill_en,
  input  logic [IW-1:0]                     i_fill_idx,
  input  logic [TW-1:0]                     i_fill_tag,
  input  logic [WORDS-1:0][DATA_WIDTH-1:0]  i_fill_line,
  input  logic                              i_wr_en,
  input  logic [IW-1:0]                     i_wr_idx,
  input  logic [OFFSET_W-1:0]               i_wr_off,
  input  logic [DATA_WIDTH-1:0]             i_wr_data,
  input  logic [IW-1:0]                     i_rd_idx,
  input  logic [TW-1:0]                     i_rd_tag,
  output logic [WORDS-1:0][DATA_WIDTH-1:0]  o_rd_line,
  output logic                              o_hit
);

  logic [LINES-1:0]                    r_valid;
  logic [TW-1:0]                       r_tag  [LINES];
  logic [WORDS-1:0][DATA_WIDTH-1:0]    r_data [LINES];

  // Only the valid bits are reset; tags and data are don't-care until filled.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_fill_en) begin
      r_valid[i_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_fill_en) begin
      r_tag[i_fill_idx]  <= i_fill_tag;
      r_data[i_fill_idx] <= i_fill_line;
    end else if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    end
  end

  assign o_rd_line = r_data[i_rd_idx];
  assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller between
// the CPU load/store port and main memory (4-word line fills, 1-word write-throughs).
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LINES      = 32
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  Mem_Wr,
  output logic                  EnMain_Rd,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] Data_in,
  input  logic [DATA_WIDTH-1:0] cache_in0,
  input  logic [DATA_WIDTH-1:0] cache_in1,
  input  logic [DATA_WIDTH-1:0] cache_in2,
  input  logic [DATA_WIDTH-1:0] cache_in3,
  input  logic                  Ready,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);

  localparam int IW = index_w(LINES);
  localparam int TW = tag_w(ADDR_WIDTH, LINES);

  state_e                           r_state;
  logic [ADDR_WIDTH-1:0]            r_addr;
  logic [DATA_WIDTH-1:0]            r_wdata;
  logic [DATA_WIDTH-1:0]            r_rdata;
  logic                             r_ack;
  logic                             r_mem_wr;
  logic                             r_en_rd;
  logic [CNT_W-1:0]                 r_hit_cnt;
  logic [CNT_W-1:0]                 r_miss_cnt;

  logic [ADDR_WIDTH-1:0]            w_lk_addr;
  logic [OFFSET_W-1:0]              w_off;
  logic [IW-1:0]                    w_idx;
  logic [TW-1:0]                    w_tag;
  logic                             w_hit;
  logic                             w_fill_en;
  logic                             w_wr_en;
  logic [WORDS-1:0][DATA_WIDTH-1:0] w_line;
  logic [WORDS-1:0][DATA_WIDTH-1:0] w_fill;

  // In IDLE the lookup must see the live request; afterwards the latched address.
  assign w_lk_addr = (r_state == IDLE) ? cpu_addr : r_addr;
  assign w_off     = w_lk_addr[OFFSET_W-1:0];
  assign w_idx     = w_lk_addr[OFFSET_W +: IW];
  assign w_tag     = w_lk_addr[ADDR_WIDTH-1 -: TW];
  assign w_fill    = {cache_in3, cache_in2, cache_in1, cache_in0};
  assign w_fill_en = (r_state == FILL) && Ready;
  assign w_wr_en   = (r_state == WRITE) && Ready && w_hit;

  dcache_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINES      (LINES),
    .IW         (IW),
    .TW         (TW)
  ) u_store (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .i_fill_en   (w_fill_en),
    .i_fill_idx  (w_idx),
    .i_fill_tag  (w_tag),
    .i_fill_line (w_fill),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_idx),
    .i_wr_off    (w_off),
    .i_wr_data   (r_wdata),
    .i_rd_idx    (w_idx),
    .i_rd_tag    (w_tag),
    .o_rd_line   (w_line),
    .o_hit       (w_hit)
  );

  // Controller FSM with registered request, ack, read data and counters.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_ack      <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_en_rd    <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            if (cpu_we) begin
              r_mem_wr <= 1'b1;
              r_state  <= WRITE;
            end else if (w_hit) begin
              r_rdata   <= w_line[w_off];
              r_hit_cnt <= sat_inc(r_hit_cnt);
              r_ack     <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_miss_cnt <= sat_inc(r_miss_cnt);
              r_en_rd    <= 1'b1;
              r_state    <= FILL;
            end
          end
        end
        FILL: begin
          if (Ready) begin
            r_en_rd <= 1'b0;
            r_rdata <= w_fill[w_off];
            r_ack   <= 1'b1;
            r_state <= DONE;
          end
        end
        WRITE: begin
          if (Ready) begin
            r_mem_wr <= 1'b0;
            r_ack    <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Requests drop in the Ready cycle so memory never counts a phantom extra beat.
  assign EnMain_Rd = r_en_rd & ~Ready;
  assign Mem_Wr    = r_mem_wr & ~Ready;
  assign cpu_ack   = r_ack;
  assign cpu_rdata = r_rdata;
  assign Address   = r_addr;
  assign Data_in   = r_wdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench: behavioural memory plus a transparent-cache reference model.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [9:0]  cpu_addr = 10'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        Mem_Wr;
  logic        EnMain_Rd;
  logic [9:0]  Address;
  logic [31:0] Data_in;
  logic [31:0] cache_in0, cache_in1, cache_in2, cache_in3;
  logic        Ready;
  logic [15:0] hit_cnt, miss_cnt;

  always #5 CLK = ~CLK;

  dcache_ctrl dut (
    .CLK(CLK), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .Mem_Wr(Mem_Wr), .EnMain_Rd(EnMain_Rd),
    .Address(Address), .Data_in(Data_in),
    .cache_in0(cache_in0), .cache_in1(cache_in1), .cache_in2(cache_in2),
    .cache_in3(cache_in3), .Ready(Ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Main memory: line read done after 2 sampled request beats, write after 4.
  logic [31:0] mem [1024];
  logic [1:0]  mem_cnt;
  logic        mem_ready;
  assign Ready     = mem_ready;
  assign cache_in0 = mem[{Address[9:2], 2'd0}];
  assign cache_in1 = mem[{Address[9:2], 2'd1}];
  assign cache_in2 = mem[{Address[9:2], 2'd2}];
  assign cache_in3 = mem[{Address[9:2], 2'd3}];

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_cnt   <= 2'd0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
    end else if (mem_ready) begin
      mem_ready <= 1'b0;
    end else if (EnMain_Rd) begin
      if (mem_cnt == 2'd1) begin
        mem_ready <= 1'b1;
        mem_cnt   <= 2'd0;
      end else mem_cnt <= mem_cnt + 2'd1;
    end else if (Mem_Wr) begin
      if (mem_cnt == 2'd3) begin
        mem_ready    <= 1'b1;
        mem_cnt      <= 2'd0;
        mem[Address] <= Data_in;
      end else mem_cnt <= mem_cnt + 2'd1;
    end
  end

  // Reference: the cache is transparent over memory; only hit/miss tracking is kept.
  logic [31:0] ref_mem [1024];
  logic        ref_valid [32];
  int          ref_tag [32];
  int          exp_hit, exp_miss;
  int          n_pass = 0;
  int          n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 0;
    end
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_mem_wr", {31'd0, Mem_Wr}, 32'd0);
    chk("rst_en_rd", {31'd0, EnMain_Rd}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_addr", {22'd0, Address}, 32'd0);
    chk("rst_data_in", Data_in, 32'd0);
    chk("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
  endtask

  task automatic do_req(input logic we, input logic [9:0] a, input logic [31:0] wd);
    int idx, tg, cyc, rd_c, wr_c, both, exp_edge, exp_rd, exp_wr;
    logic hit, acked;
    idx = (int'(a) / 4) % 32;
    tg  = int'(a) / 128;
    hit = !we && ref_valid[idx] && (ref_tag[idx] == tg);
    if (we) begin
      exp_edge = 5; exp_rd = 0; exp_wr = 4;
      ref_mem[a] = wd;
    end else if (hit) begin
      exp_edge = 0; exp_rd = 0; exp_wr = 0;
      exp_hit++;
    end else begin
      exp_edge = 3; exp_rd = 2; exp_wr = 0;
      exp_miss++;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
    end
    @(negedge CLK);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    cyc = 0; rd_c = 0; wr_c = 0; both = 0; acked = 1'b0;
    while (!acked && cyc < 20) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (EnMain_Rd) rd_c++;
      if (Mem_Wr) wr_c++;
      if (EnMain_Rd && Mem_Wr) both++;
      acked = cpu_ack;
    end
    cpu_req = 1'b0;
    chk("ack_edge", acked ? cyc - 1 : 99, exp_edge);
    chk("en_rd_cycles", rd_c, exp_rd);
    chk("mem_wr_cycles", wr_c, exp_wr);
    chk("req_overlap", both, 0);
    chk("address", {22'd0, Address}, {22'd0, a});
    if (!we) chk("rdata", cpu_rdata, ref_mem[a]);
    if (we) chk("data_in", Data_in, wd);
    if (we) chk("mem_word", mem[a], wd);
    chk("hit_cnt", {16'd0, hit_cnt}, exp_hit);
    chk("miss_cnt", {16'd0, miss_cnt}, exp_miss);
    @(posedge CLK);
    #1;
    chk("ack_pulse", {31'd0, cpu_ack}, 32'd0);
  endtask

  initial begin
    logic [9:0] ra;
    reset_model();
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs();
    @(negedge CLK);
    rst_n = 1'b1;

    do_req(1'b0, 10'h004, 32'd0);
    do_req(1'b1, 10'h005, 32'hDEADBEEF);
    do_req(1'b0, 10'h005, 32'd0);
    do_req(1'b0, 10'h005, 32'd0);
    do_req(1'b1, 10'h006, 32'h12345678);
    do_req(1'b0, 10'h006, 32'd0);
    do_req(1'b0, 10'h084, 32'd0);
    do_req(1'b0, 10'h004, 32'd0);

    // Abort a write-through in its second WRITE cycle.
    @(negedge CLK);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h00A; cpu_wdata = 32'hCAFE0001;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("mid_write_mem_wr", {31'd0, Mem_Wr}, 32'd1);
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk_reset_outputs();
    reset_model();
    @(negedge CLK);
    rst_n = 1'b1;
    do_req(1'b0, 10'h005, 32'd0);
    do_req(1'b1, 10'h00A, 32'hCAFE0001);
    do_req(1'b0, 10'h00A, 32'd0);

    for (int n = 0; n < 60; n++) begin
      ra = 10'($urandom_range(0, 1) << 7) | 10'($urandom_range(0, 3) << 2) | 10'($urandom_range(0, 3));
      do_req($urandom_range(0, 2) == 0, ra, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
